// File: rtl/ram_param_loader_if.sv
// CPU-slot bus plus loader/clear side-band of the SAP RAM.
// The slave modport is the RAM; the master modport is the CPU/boot controller.
interface ram_param_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  clear_req;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  busy;
  logic [ADDR_WIDTH:0]   load_count;

  modport slave (
    input  we, address, data_in, clear_req, load_start, load_valid, load_data, load_last,
    output data_out, load_ready, busy, load_count
  );

  modport master (
    output we, address, data_in, clear_req, load_start, load_valid, load_data, load_last,
    input  data_out, load_ready, busy, load_count
  );
endinterface

// File: rtl/ram_param_loader.sv
// Parametrised single-port RAM with a hardware clear engine and a streaming
// program-load port; the CPU side works only while the engine is idle.
module ram_param_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_param_loader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    data_out_d   = data_out_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = '0;

    unique case (state_q)
      S_IDLE: begin
        // read samples the array before this edge's write: old data on collision
        data_out_d = mem[bus.address];
        if (bus.we) begin
          mem_we    = 1'b1;
          mem_waddr = bus.address;
          mem_wdata = bus.data_in;
        end
        if (bus.load_start) begin
          state_d      = S_LOAD;
          ptr_d        = '0;
          load_count_d = '0;
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == PTR_LAST) state_d = S_IDLE;
      end
      S_LOAD: begin
        if (bus.load_valid) begin
          mem_we       = 1'b1;
          mem_wdata    = bus.load_data;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);
          load_count_d = load_count_q + (ADDR_WIDTH+1)'(1);
          if (bus.load_last || ptr_q == PTR_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear_req overrides everything; a beat offered in the same cycle is dropped
    if (bus.clear_req) begin
      state_d = S_CLEAR;
      ptr_d   = '0;
      if (state_q == S_LOAD) begin
        mem_we       = 1'b0;
        load_count_d = load_count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) state_q <= S_CLEAR;
      else                state_q <= S_IDLE;
      ptr_q        <= '0;
      load_count_q <= '0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      data_out_q   <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.data_out   = data_out_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.load_ready = (state_q == S_LOAD);
  assign bus.load_count = load_count_q;
endmodule

// File: tb/tb_ram_param_loader.sv
// Randomised self-checking bench: a default 16x8 instance checked against an
// array model, plus a 64x16 clear-on-reset instance.
module tb_ram_param_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   errs = 0;
  int   checks = 0;

  ram_param_loader_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) bus_a ();
  ram_param_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus_b ();

  ram_param_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0)) u_a (
    .clk(clk), .reset_n(rst_a), .bus(bus_a));
  ram_param_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk(clk), .reset_n(rst_b), .bus(bus_b));

  logic [7:0] ref_a [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.we = 1'b0; bus_a.address = '0; bus_a.data_in = '0;
    bus_a.clear_req = 1'b0; bus_a.load_start = 1'b0;
    bus_a.load_valid = 1'b0; bus_a.load_data = '0; bus_a.load_last = 1'b0;
  endtask

  task automatic wr_a(input int a, input logic [7:0] d);
    bus_a.we = 1'b1; bus_a.address = 4'(a); bus_a.data_in = d;
    step();
    bus_a.we = 1'b0;
    ref_a[a] = d;
  endtask

  task automatic rd_a(input int a, output logic [7:0] d);
    bus_a.we = 1'b0; bus_a.address = 4'(a);
    step();
    d = bus_a.data_out;
  endtask

  task automatic check_all_a(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      rd_a(i, d);
      chk(tag, d, ref_a[i]);
    end
  endtask

  task automatic fill_a(input logic [7:0] d);
    for (int i = 0; i < 16; i++) wr_a(i, d);
  endtask

  // counts cycles (including the current one) during which busy is seen high
  task automatic wait_busy(input bit which_b, output int n);
    n = 0;
    while ((which_b ? bus_b.busy : bus_a.busy) && n < 500) begin
      n++;
      step();
    end
  endtask

  task automatic zero_ref_a();
    for (int i = 0; i < 16; i++) ref_a[i] = 8'h00;
  endtask

  // stream a whole image; caller guarantees the stream ends by last or by depth
  task automatic load_a(input logic [7:0] beats[$], input bit use_last,
                        input int stall_lo, input int stall_hi);
    bus_a.load_start = 1'b1;
    step();
    bus_a.load_start = 1'b0;
    chk("ld_ready_start", bus_a.load_ready, 1);
    chk("ld_count_start", bus_a.load_count, 0);
    for (int i = 0; i < beats.size(); i++) begin
      repeat ($urandom_range(stall_hi, stall_lo)) step();
      bus_a.load_valid = 1'b1;
      bus_a.load_data  = beats[i];
      bus_a.load_last  = use_last && (i == beats.size() - 1);
      step();
      bus_a.load_valid = 1'b0;
      bus_a.load_last  = 1'b0;
      ref_a[i] = beats[i];
      if (i < beats.size() - 1) chk("ld_ready_mid", bus_a.load_ready, 1);
    end
    chk("ld_ready_end", bus_a.load_ready, 0);
    chk("ld_busy_end", bus_a.busy, 0);
  endtask

  task automatic dump_a();
    for (int i = 0; i < 16; i++) $display("mem[%0d] = %h", i, u_a.mem[i]);
  endtask

  initial begin
    logic [7:0]  d;
    logic [7:0]  q[$];
    int          n;
    int          a;
    bit          w;

    idle_a();
    bus_b.we = 1'b0; bus_b.address = '0; bus_b.data_in = '0;
    bus_b.clear_req = 1'b0; bus_b.load_start = 1'b0;
    bus_b.load_valid = 1'b0; bus_b.load_data = '0; bus_b.load_last = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    #12;
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_ready", bus_a.load_ready, 0);
    chk("rst_dout", bus_a.data_out, 0);
    chk("rst_count", bus_a.load_count, 0);
    chk("rst_b_busy", bus_b.busy, 1);
    chk("rst_b_ready", bus_b.load_ready, 0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    step();

    // defined contents before the model is trusted
    for (int i = 0; i < 16; i++) wr_a(i, 8'($urandom));

    wr_a(3, 8'hA5);
    rd_a(3, d);
    chk("rd_after_wr", d, 8'hA5);
    bus_a.we = 1'b1; bus_a.address = 4'd3; bus_a.data_in = 8'h5A;
    step();
    bus_a.we = 1'b0;
    chk("rdw_old", bus_a.data_out, 8'hA5);
    ref_a[3] = 8'h5A;
    step();
    chk("rdw_new", bus_a.data_out, 8'h5A);

    repeat (40) begin
      a = $urandom_range(15, 0);
      w = 1'($urandom_range(1, 0));
      d = 8'($urandom);
      bus_a.we = w; bus_a.address = 4'(a); bus_a.data_in = d;
      step();
      chk("cpu_rand", bus_a.data_out, ref_a[a]);
      if (w) ref_a[a] = d;
    end
    bus_a.we = 1'b0;

    // clear: CPU write of 0x11 @0 held through the whole busy window
    fill_a(8'hFF);
    bus_a.clear_req = 1'b1;
    step();
    bus_a.clear_req = 1'b0;
    bus_a.we = 1'b1; bus_a.address = 4'd0; bus_a.data_in = 8'h11;
    wait_busy(1'b0, n);
    bus_a.we = 1'b0;
    chk("clr_busy_cycles", n, 16);
    zero_ref_a();
    check_all_a("clr_zero");

    q = '{8'h1F, 8'h4E, 8'hE0};
    load_a(q, 1'b1, 1, 1);
    chk("ld3_count", bus_a.load_count, 3);
    check_all_a("ld3_mem");

    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    load_a(q, 1'b0, 0, 0);
    chk("full_count", bus_a.load_count, 16);
    bus_a.load_valid = 1'b1; bus_a.load_data = 8'hAA;
    step();
    bus_a.load_valid = 1'b0;
    chk("full_17th_count", bus_a.load_count, 16);
    chk("full_17th_ready", bus_a.load_ready, 0);
    check_all_a("full_mem");

    repeat (6) begin
      n = $urandom_range(16, 1);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load_a(q, (n < 16) ? 1'b1 : 1'($urandom_range(1, 0)), 0, 2);
      chk("rnd_count", bus_a.load_count, 5'(n));
      check_all_a("rnd_mem");
    end

    bus_a.clear_req = 1'b1; bus_a.load_start = 1'b1;
    step();
    bus_a.clear_req = 1'b0; bus_a.load_start = 1'b0;
    chk("prio_busy", bus_a.busy, 1);
    chk("prio_ready", bus_a.load_ready, 0);
    wait_busy(1'b0, n);
    chk("prio_cycles", n, 16);
    zero_ref_a();
    check_all_a("prio_zero");

    // abort a load after 5 beats
    fill_a(8'hC3);
    bus_a.load_start = 1'b1;
    step();
    bus_a.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_a.load_valid = 1'b1; bus_a.load_data = 8'(8'h40 + i);
      step();
    end
    bus_a.load_valid = 1'b0;
    chk("abort_count_pre", bus_a.load_count, 5);
    bus_a.clear_req = 1'b1;
    step();
    bus_a.clear_req = 1'b0;
    chk("abort_ready", bus_a.load_ready, 0);
    wait_busy(1'b0, n);
    chk("abort_cycles", n, 16);
    chk("abort_count", bus_a.load_count, 5);
    zero_ref_a();
    check_all_a("abort_zero");

    rst_b = 1'b1;
    wait_busy(1'b1, n);
    chk("b_busy_cycles", n, 64);
    for (int i = 0; i < 64; i++) begin
      bus_b.address = 6'(i);
      step();
      chk("b_zero", bus_b.data_out, 0);
    end

    // reset mid-load: outputs drop immediately, written words persist
    wr_a(5, 8'h77);
    rd_a(5, d);
    chk("pre_rst_dout", d, 8'h77);
    bus_a.load_start = 1'b1;
    step();
    bus_a.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_a.load_valid = 1'b1; bus_a.load_data = 8'(8'h31 + i);
      step();
      ref_a[i] = 8'(8'h31 + i);
    end
    bus_a.load_valid = 1'b0;
    chk("pre_rst_ready", bus_a.load_ready, 1);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_busy", bus_a.busy, 0);
    chk("mid_rst_ready", bus_a.load_ready, 0);
    chk("mid_rst_dout", bus_a.data_out, 0);
    chk("mid_rst_count", bus_a.load_count, 0);
    step();
    rst_a = 1'b1;
    step();
    check_all_a("rst_keep");

    dump_a();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ram_param_loader.md
Name: ram_param_loader

Overview:
- Parametrised synchronous single-port RAM for the SAP CPU. It replaces the fixed 16x8 RAM.
- Adds a hardware clear engine and a streaming program-load port. These let software images or a UART loader fill memory at run time instead of relying on synthesis-time initial contents.
- Sits on the CPU bus at the RAM slot. The loader/clear side is driven by a debug/boot controller.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address width in bits; DEPTH = 2**ADDR_WIDTH words.
- CLEAR_ON_RESET, 0: 1 = enter CLEAR automatically on reset release; 0 = enter IDLE.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  CPU write enable (RI).
- address  in  ADDR_WIDTH  CPU address.
- data_in  in  DATA_WIDTH  CPU write data.
- data_out  out  DATA_WIDTH  registered CPU read data.
- clear_req  in  1  single-cycle pulse; zero the whole array.
- load_start  in  1  single-cycle pulse; begin a stream load at address 0.
- load_valid  in  1  loader beat valid.
- load_data  in  DATA_WIDTH  loader beat data.
- load_last  in  1  qualifies the final beat of a stream.
- load_ready  out  1  loader may present beats; high only in LOAD.
- busy  out  1  high in CLEAR or LOAD; the CPU must stall on it.
- load_count  out  ADDR_WIDTH+1  beats accepted in the current or most recent load.

Behaviour:
Reset (reset_n low, asynchronous):
- State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
- Internal pointer, load_count and data_out are 0.
- Memory contents are not reset.

State machine (states IDLE, CLEAR, LOAD):
- busy = (state != IDLE).
- load_ready = (state == LOAD).
- Both are decoded from registered state (no input-to-output combinational path).

IDLE:
- Every cycle, data_out <= mem[address]. Read latency is 1 cycle.
- If we is high, mem[address] <= data_in. A read and write to the same address in the same cycle returns the OLD data; the new data is visible on the next read.
- clear_req -> CLEAR with ptr=0. If clear_req and load_start are asserted together, clear_req wins.
- Otherwise load_start -> LOAD with ptr=0 and load_count=0.

CLEAR:
- Each cycle, mem[ptr] <= 0 and ptr++.
- After writing ptr == DEPTH-1, go to IDLE. busy is high for exactly DEPTH cycles.

LOAD:
- A beat is accepted when load_valid && load_ready: mem[ptr] <= load_data, ptr++, load_count++.
- Cycles without load_valid are stalls with no change.
- Exit to IDLE after accepting a beat with load_last = 1, or after accepting the beat at ptr == DEPTH-1, whichever comes first.
- A full-depth load leaves load_count = DEPTH. The extra bit exists so DEPTH is representable.
- load_start during LOAD is ignored.

CLEAR and LOAD, common rules:
- CPU we is ignored.
- data_out holds its last IDLE value.
- clear_req in any state, including mid-CLEAR and mid-LOAD, restarts CLEAR at ptr=0. An interrupted load is abandoned and load_count holds its partial value.

load_count holds after exit until the next load_start or reset.

Reset mid-operation: state returns immediately to the reset state. Words already written stay written.

Pointer arithmetic: modulo DEPTH. It is never used past DEPTH-1 because of the exit rules above.

A dump task prints all DEPTH words (hex, width-correct) for simulation benches.

Test Plan:
- CPU read/write, defaults: reset, write 0xA5 @3, then read @3 with we=0 -> data_out=0xA5 one cycle after the address is presented. Simultaneous write 0x5A/read @3 -> data_out=0xA5, next cycle 0x5A.
- Clear: fill all 16 words with 0xFF, pulse clear_req -> busy high exactly 16 cycles, CPU write of 0x11 @0 during busy is ignored, afterwards every word reads 0x00.
- Stream load with stalls: load_start, beats 0x1F,0x4E,0xE0 with one idle cycle between each, load_last on the third -> load_ready drops after the third beat, load_count=3, mem[0..2] match, mem[3] unchanged.
- Full-depth load without load_last: 16 beats 0x00..0x0F -> auto exit after the 16th beat, load_count=16, a 17th load_valid is not accepted (load_ready=0), mem[i]=i.
- Priority/abort: clear_req and load_start in the same cycle -> CLEAR entered. clear_req after 5 load beats -> load abandoned, load_count=5, array all zero after 16 cycles.
- Parametrisation and reset: DATA_WIDTH=16, ADDR_WIDTH=6, CLEAR_ON_RESET=1 -> busy high 64 cycles after reset release, then all words 0x0000. Assert reset_n low mid-LOAD -> busy=0, load_ready=0 and data_out=0 immediately.
